// File: rtl/readout_tx.sv
// SPI-side transmitter for the readout instruction: streams the sample memory
// out on miso MSB-first, clocked by an oversampled mode-0 SPI master.
module readout_tx #(
  parameter int WORD_W    = 8,
  parameter int NUM_WORDS = 64,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              csb,
  input  logic              inst_readout,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [WORD_W-1:0] rd_data,
  output logic              miso,
  output logic              miso_oe,
  output logic              readout_busy,
  output logic              readout_done
);

  localparam int BCNT_W = $clog2(WORD_W + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH0 = 3'd1;
  localparam logic [2:0] ST_FETCH1 = 3'd2;
  localparam logic [2:0] ST_READY  = 3'd3;
  localparam logic [2:0] ST_SHIFT  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]        sclk_q_r, csb_q_r, inst_q_r;
  logic              arm_s, shift_ev_s, frame_end_s;

  logic [2:0]        state_r, state_s;
  logic [WORD_W-1:0] shreg_r, shreg_s;
  logic [WORD_W-1:0] cur_word_r, cur_word_s;
  logic [WORD_W-1:0] nxt_buf_r, nxt_buf_s;
  logic              nxt_valid_r, nxt_valid_s;
  logic [BCNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic [ADDR_W-1:0] wcnt_r, wcnt_s;
  logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
  logic              rd_en_r, rd_en_s;
  logic              rd_vld_r;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              miso_r, miso_s;
  logic              miso_oe_r;

  // Two synchroniser stages plus one history flop per asynchronous input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q_r <= 3'b000;
      csb_q_r  <= 3'b111;
      inst_q_r <= 3'b000;
    end else begin
      sclk_q_r <= {sclk_q_r[1:0], sclk};
      csb_q_r  <= {csb_q_r[1:0], csb};
      inst_q_r <= {inst_q_r[1:0], inst_readout};
    end
  end

  assign arm_s       = inst_q_r[1] & ~inst_q_r[2];
  assign shift_ev_s  = ~sclk_q_r[1] & sclk_q_r[2] & ~csb_q_r[1];
  assign frame_end_s = csb_q_r[1] & ~csb_q_r[2];

  // Next-state logic for the FSM, shift datapath and memory read port.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    cur_word_s  = cur_word_r;
    nxt_buf_s   = nxt_buf_r;
    nxt_valid_s = nxt_valid_r;
    bit_cnt_s   = bit_cnt_r;
    wcnt_s      = wcnt_r;
    rd_addr_s   = rd_addr_r;
    rd_en_s     = 1'b0;
    busy_s      = busy_r;
    done_s      = done_r;

    // Any read returning outside FETCH0 is a prefetch into the holding buffer.
    if (rd_vld_r && (state_r != ST_FETCH0)) begin
      nxt_buf_s   = rd_data;
      nxt_valid_s = 1'b1;
    end else begin
      nxt_buf_s   = nxt_buf_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (arm_s) begin
          wcnt_s      = '0;
          rd_addr_s   = '0;
          rd_en_s     = 1'b1;
          done_s      = 1'b0;
          busy_s      = 1'b1;
          nxt_valid_s = 1'b0;
          bit_cnt_s   = '0;
          state_s     = ST_FETCH0;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH0: begin
        if (rd_vld_r) begin
          shreg_s    = rd_data;
          cur_word_s = rd_data;
          state_s    = ST_READY;
          if (NUM_WORDS > 1) begin
            rd_addr_s = ADDR_W'(1);
            rd_en_s   = 1'b1;
          end else begin
            rd_en_s   = 1'b0;
          end
        end else begin
          state_s = ST_FETCH0;
        end
      end
      ST_FETCH1: begin
        if (nxt_valid_r) begin
          shreg_s     = nxt_buf_r;
          cur_word_s  = nxt_buf_r;
          nxt_valid_s = 1'b0;
          state_s     = ST_READY;
          if (int'(wcnt_r) + 1 < NUM_WORDS) begin
            rd_addr_s = wcnt_r + ADDR_W'(1);
            rd_en_s   = 1'b1;
          end else begin
            rd_en_s   = 1'b0;
          end
        end else begin
          state_s = ST_FETCH1;
        end
      end
      ST_READY, ST_SHIFT: begin
        if (shift_ev_s) begin
          shreg_s = {shreg_r[WORD_W-2:0], 1'b0};
          if (bit_cnt_r == BCNT_W'(WORD_W - 1)) begin
            bit_cnt_s = '0;
            if (wcnt_r == ADDR_W'(NUM_WORDS - 1)) begin
              busy_s  = 1'b0;
              done_s  = 1'b1;
              state_s = ST_DONE;
            end else if (nxt_valid_r) begin
              shreg_s     = nxt_buf_r;
              cur_word_s  = nxt_buf_r;
              nxt_valid_s = 1'b0;
              wcnt_s      = wcnt_r + ADDR_W'(1);
              state_s     = ST_SHIFT;
              if (int'(wcnt_r) + 2 < NUM_WORDS) begin
                rd_addr_s = wcnt_r + ADDR_W'(2);
                rd_en_s   = 1'b1;
              end else begin
                rd_en_s   = 1'b0;
              end
            end else begin
              wcnt_s  = wcnt_r + ADDR_W'(1);
              state_s = ST_FETCH1;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + BCNT_W'(1);
            state_s   = ST_SHIFT;
          end
        end else if (frame_end_s && (bit_cnt_r != '0)) begin
          // Partial word is abandoned and resent whole in the next frame.
          shreg_s   = cur_word_r;
          bit_cnt_s = '0;
          state_s   = ST_READY;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if ((state_s == ST_READY) || (state_s == ST_SHIFT)) begin
      miso_s = shreg_s[WORD_W-1];
    end else begin
      miso_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      shreg_r     <= '0;
      cur_word_r  <= '0;
      nxt_buf_r   <= '0;
      nxt_valid_r <= 1'b0;
      bit_cnt_r   <= '0;
      wcnt_r      <= '0;
      rd_addr_r   <= '0;
      rd_en_r     <= 1'b0;
      rd_vld_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      cur_word_r  <= cur_word_s;
      nxt_buf_r   <= nxt_buf_s;
      nxt_valid_r <= nxt_valid_s;
      bit_cnt_r   <= bit_cnt_s;
      wcnt_r      <= wcnt_s;
      rd_addr_r   <= rd_addr_s;
      rd_en_r     <= rd_en_s;
      rd_vld_r    <= rd_en_r;
      busy_r      <= busy_s;
      done_r      <= done_s;
      miso_r      <= miso_s;
      miso_oe_r   <= ~csb_q_r[1];
    end
  end

  assign rd_addr      = rd_addr_r;
  assign rd_en        = rd_en_r;
  assign miso         = miso_r;
  assign miso_oe      = miso_oe_r;
  assign readout_busy = busy_r;
  assign readout_done = done_r;

endmodule

// File: tb/tb_readout_tx.sv
// Directed scoreboard bench for readout_tx: a mode-0 SPI master model with a
// 4-word synchronous memory behind the read port.
module tb_readout_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sclk = 1'b0;
  logic       csb = 1'b1;
  logic       inst_readout = 1'b0;
  logic [1:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data = 8'h00;
  logic       miso, miso_oe, readout_busy, readout_done;

  logic [7:0] mem [4];
  logic [7:0] sb_q [$];
  logic [1:0] addr_q [$];
  int         rd_cnt = 0;
  int         dbl_cnt = 0;
  logic       rd_en_d = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic [63:0] bits;
  int          base;

  readout_tx #(.WORD_W(8), .NUM_WORDS(4)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .csb(csb),
    .inst_readout(inst_readout), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .miso(miso), .miso_oe(miso_oe),
    .readout_busy(readout_busy), .readout_done(readout_done));

  always #5 clk = ~clk;

  // Synchronous memory plus read-port monitor.
  always @(posedge clk) begin
    rd_en_d <= rd_en;
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      rd_cnt  <= rd_cnt + 1;
      addr_q.push_back(rd_addr);
    end
    if (rd_en && rd_en_d) dbl_cnt <= dbl_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_frame(input int n, input bit end_cs, output logic [63:0] b);
    b = '0;
    csb = 1'b0;
    #100;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      b = {b[62:0], miso};
      #50;
      sclk = 1'b0;
      #50;
    end
    if (end_cs) begin
      #100;
      csb = 1'b1;
      #200;
    end
  endtask

  task automatic check_bytes(input string tag, input logic [63:0] b, input int nb);
    logic [7:0] e;
    for (int k = 0; k < nb; k++) begin
      e = sb_q.pop_front();
      chk(tag, b[8*(nb-1-k) +: 8], {56'h0, e});
    end
  endtask

  task automatic arm();
    for (int i = 0; i < 4; i++) sb_q.push_back(mem[i]);
    addr_q.delete();
    inst_readout = 1'b1;
    #100;
    inst_readout = 1'b0;
    #300;
  endtask

  task automatic check_addrs();
    chk("addr_cnt", 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("addr_seq", {62'h0, addr_q[i]}, 64'(i));
    chk("rd_en_pulse", 64'(dbl_cnt), 64'd0);
  endtask

  initial begin
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h01;
    #27;
    chk("rst_miso", {63'h0, miso}, 64'd0);
    chk("rst_oe", {63'h0, miso_oe}, 64'd0);
    chk("rst_rden", {63'h0, rd_en}, 64'd0);
    chk("rst_addr", {62'h0, rd_addr}, 64'd0);
    chk("rst_busy", {63'h0, readout_busy}, 64'd0);
    chk("rst_done", {63'h0, readout_done}, 64'd0);
    rstn = 1'b1;
    #100;

    // sclk activity before any arm
    base = rd_cnt;
    spi_frame(8, 1'b1, bits);
    chk("prearm_miso", bits, 64'd0);
    chk("prearm_rden", 64'(rd_cnt - base), 64'd0);
    chk("prearm_busy", {63'h0, readout_busy}, 64'd0);

    // one 32-bit frame
    arm();
    chk("arm_busy", {63'h0, readout_busy}, 64'd1);
    chk("arm_done", {63'h0, readout_done}, 64'd0);
    spi_frame(32, 1'b1, bits);
    check_bytes("frame32", bits, 4);
    chk("f32_done", {63'h0, readout_done}, 64'd1);
    chk("f32_busy", {63'h0, readout_busy}, 64'd0);
    check_addrs();

    // re-arm after done, four 8-bit frames
    arm();
    chk("rearm_done", {63'h0, readout_done}, 64'd0);
    for (int f = 0; f < 4; f++) begin
      spi_frame(8, 1'b1, bits);
      check_bytes("frame8", bits, 1);
      chk("gap_oe", {63'h0, miso_oe}, 64'd0);
    end
    chk("f8_done", {63'h0, readout_done}, 64'd1);
    check_addrs();

    // aborted partial word is resent in full
    arm();
    spi_frame(8, 1'b1, bits);
    check_bytes("pre_abort", bits, 1);
    spi_frame(3, 1'b1, bits);
    chk("partial3", bits, 64'b001);
    spi_frame(24, 1'b1, bits);
    check_bytes("post_abort", bits, 3);
    chk("abort_done", {63'h0, readout_done}, 64'd1);

    // second arm during SHIFT is ignored
    arm();
    fork
      spi_frame(32, 1'b1, bits);
      begin
        #1500;
        inst_readout = 1'b1;
        #100;
        inst_readout = 1'b0;
      end
    join
    check_bytes("rearm_ignored", bits, 4);
    chk("ign_done", {63'h0, readout_done}, 64'd1);

    // reset in the middle of word 2
    arm();
    spi_frame(8, 1'b1, bits);
    check_bytes("pre_rst0", bits, 1);
    spi_frame(8, 1'b1, bits);
    check_bytes("pre_rst1", bits, 1);
    spi_frame(3, 1'b0, bits);
    chk("word2_bits", bits, 64'b111);
    chk("word2_miso", {63'h0, miso}, 64'd1);
    sb_q.delete();
    rstn = 1'b0;
    #1;
    chk("mid_rst_miso", {63'h0, miso}, 64'd0);
    chk("mid_rst_oe", {63'h0, miso_oe}, 64'd0);
    chk("mid_rst_busy", {63'h0, readout_busy}, 64'd0);
    chk("mid_rst_done", {63'h0, readout_done}, 64'd0);
    #9;
    csb = 1'b1;
    #100;
    rstn = 1'b1;
    #100;
    base = rd_cnt;
    spi_frame(16, 1'b1, bits);
    chk("post_rst_miso", bits, 64'd0);
    chk("post_rst_rden", 64'(rd_cnt - base), 64'd0);
    chk("post_rst_busy", {63'h0, readout_busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/readout_tx.md
Name: readout_tx

Overview:
- SPI-side transmitter for the readout instruction.
- An `inst_readout` pulse arms the block. It streams the sample memory out on `miso`, one word after another, MSB-first, clocked by the external SPI master (mode 0).
- Sits between the sample storage read port and the SPI pad. It runs on the on-chip digital clock and oversamples `sclk`/`csb`.

Parameters:
- WORD_W, 8, bits per memory word shifted out.
- NUM_WORDS, 64, number of words per readout (addresses 0..NUM_WORDS-1).
- ADDR_W, $clog2(NUM_WORDS), width of rd_addr.

Ports:
- clk  in  1  digital clock; must be >= 8x sclk frequency.
- rstn  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master (asynchronous to clk).
- csb  in  1  SPI chip select, active low (asynchronous to clk).
- inst_readout  in  1  readout command from instruction decode (async level pulse).
- rd_addr  out  ADDR_W  sample memory read address.
- rd_en  out  1  read strobe; rd_data is valid exactly 1 clk after rd_en.
- rd_data  in  WORD_W  sample memory read data.
- miso  out  1  serial data out.
- miso_oe  out  1  pad output enable.
- readout_busy  out  1  high from arm until the last bit has been shifted.
- readout_done  out  1  high after a full readout, until the next arm or reset.

Behaviour:
- **Reset values:** all outputs 0; FSM in IDLE; shift register, holding buffer, bit counter and word counter cleared.
- **Input synchronisation:** sclk, csb and inst_readout each pass through a 2-FF synchroniser. Edge detect uses a third flop.
  - arm = rising edge of inst_readout.
  - shift_ev = falling edge of sclk while synced csb = 0.
  - frame_end = rising edge of csb.
- **miso_oe:** equals !csb_sync, registered.
- **miso:** equals shreg[WORD_W-1] in states READY and SHIFT; 0 in all other states.
- **FSM states:** IDLE, FETCH0, FETCH1, READY, SHIFT, DONE.
- **IDLE / DONE:**
  - On arm: word counter = 0, rd_addr = 0, rd_en = 1 for one cycle, done = 0, busy = 1; go to FETCH0.
  - arm is ignored in all other states.
- **FETCH0:** rd_data captured into shreg and cur_word. Issue a prefetch of address 1 if NUM_WORDS > 1. Go to READY.
- **Prefetch:** data returned one cycle later goes into nxt_buf, with nxt_valid = 1.
- **READY:** waits for the master; the MSB is already on miso. The first shift_ev goes to SHIFT.
- **SHIFT:**
  - Each shift_ev: shreg <<= 1, bit_cnt++.
  - When bit_cnt reaches WORD_W on a shift_ev:
    - If the word counter equals NUM_WORDS-1, go to DONE: busy = 0, done = 1.
    - Otherwise load shreg and cur_word from nxt_buf, clear nxt_valid, increment the word counter, and issue a prefetch of the next address if one exists. bit_cnt = 0.
- **Prefetch timing:** the prefetch always completes within 2 clk. With clk >= 8x sclk, nxt_valid is guaranteed set before the word boundary.
  - If nxt_valid = 0 at the boundary, go to FETCH1: wait for the data, then go to READY. This is a defensive path only.
- **frame_end mid-word (bit_cnt != 0):** discard the partial word; reload shreg from cur_word and set bit_cnt = 0. The word is retransmitted in full in the next frame.
- **frame_end at a word boundary:** no effect. Readout spans multiple CS frames.
- **Shift events outside READY/SHIFT:** ignored; miso stays 0.
- **rd_addr:** holds the last issued address. rd_en is a single-cycle pulse per read.
- **Reset mid-readout:** asynchronous return to IDLE with all outputs 0. A new arm is required to restart.

Test Plan:
- WORD_W=8, NUM_WORDS=4, memory {A5,3C,FF,01}. Pulse inst_readout, then one CS frame of 32 sclk cycles at clk/10 -> miso bitstream A5 3C FF 01 MSB-first; done=1 after bit 32; busy=0.
- Same setup, four separate 8-bit CS frames -> same bytes received. miso_oe=0 between frames; rd_addr sequence 0,1,2,3 with one rd_en pulse each.
- csb deasserted after 3 bits of word 1 (0x3C), then a new frame -> master receives 0x3C in full; total data A5 3C FF 01.
- Second inst_readout pulse during SHIFT -> ignored; stream unchanged. After done, a new inst_readout -> done drops, stream restarts at A5.
- rstn asserted mid-word 2 -> miso=0, miso_oe=0, busy=0, done=0 immediately. Subsequent sclk activity without arm -> miso stays 0.
- Frame with sclk toggling before any arm -> miso=0, no rd_en, FSM stays IDLE.
